// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: 3-state IDLE/EXEC/WB sequencer with a 4x4 register file, an inline 4-bit ALU, and in/out valid-ready handshakes
module alu_op_sequencer #(
  parameter int RET_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [1:0]       out_addr,
  output logic             busy,
  output logic [RET_W-1:0] retired
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state, state_nx;
  logic [3:0] rf [4];
  logic       ld_q;
  logic [2:0] op_q;
  logic [1:0] rd_q;
  logic [3:0] imm_q, op_a, op_b, res, alu_rd;
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == WB;
  assign out_data  = res;
  assign out_addr  = rd_q;
  always_comb begin
    alu_rd = op_q == 3'd0 ? op_a - op_b :
             op_q == 3'd1 ? op_a + op_b :
             op_q == 3'd2 ? op_a | op_b :
             op_q == 3'd3 ? op_a & op_b :
             op_q == 3'd4 ? {op_b[3], op_b[3:1]} :
             op_q == 3'd5 ? {op_a[2:0], op_a[3]} :
             op_q == 3'd6 ? {3'b000, op_a < op_b} :
                            {3'b000, op_a == op_b};
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? EXEC : IDLE;
      EXEC:    state_nx = WB;
      WB:      state_nx = out_ready ? IDLE : WB;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rf      <= '{default: '0};
      ld_q    <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        ld_q  <= instr[9];
        op_q  <= instr[8:6];
        rd_q  <= instr[5:4];
        imm_q <= instr[3:0];
        op_a  <= rf[instr[3:2]];
        op_b  <= rf[instr[1:0]];
      end
      if (state == EXEC) begin
        res      <= ld_q ? imm_q : alu_rd;
        rf[rd_q] <= ld_q ? imm_q : alu_rd;
      end
      if (state == WB && out_ready) retired <= retired + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] instr = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [1:0] out_addr;
  logic       busy;
  logic [7:0] retired;
  typedef struct packed {logic [3:0] d; logic [1:0] a;} res_t;
  res_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [7:0] ret_m = '0;
  alu_op_sequencer #(.RET_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [9:0] ld_i(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 3'b000, rd, imm};
  endfunction
  function automatic logic [9:0] op_i(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
    return {1'b0, op, rd, rs, rt};
  endfunction
  task automatic issue(input logic [9:0] ins, input logic [3:0] exp);
    int n = 0;
    sb.push_back('{d: exp, a: ins[5:4]});
    in_valid = 1'b1;
    instr = ins;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("accept_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    instr = '0;
    check("exec_out_valid", out_valid, 0);
    check("exec_in_ready", in_ready, 0);
    check("exec_busy", busy, 1);
    @(posedge clk); #1;
    check("latency_out_valid", out_valid, 1);
  endtask
  task automatic collect(input int hold);
    res_t e;
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("result_timeout", n, 0);
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      instr = ld_i(2'd0, 4'hF);
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, e.d);
      check("hold_out_addr", out_addr, e.a);
      check("hold_in_ready", in_ready, 0);
      check("hold_retired", retired, ret_m);
    end
    in_valid = 1'b0;
    check("out_data", out_data, e.d);
    check("out_addr", out_addr, e.a);
    check("pre_retired", retired, ret_m);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ret_m++;
    check("retired", retired, ret_m);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
  endtask
  task automatic run(input logic [9:0] ins, input logic [3:0] exp, input int hold);
    issue(ins, exp);
    collect(hold);
  endtask
  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_retired", retired, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stray_out_ready", retired, 0);
    run(ld_i(2'd0, 4'd5), 4'd5, 0);
    run(ld_i(2'd1, 4'd3), 4'd3, 0);
    check("retired_two", retired, 2);
    run(op_i(3'd1, 2'd2, 2'd0, 2'd1), 4'd8, 0);
    run(op_i(3'd0, 2'd3, 2'd1, 2'd0), 4'hE, 0);
    run(op_i(3'd2, 2'd2, 2'd0, 2'd1), 4'd7, 0);
    run(op_i(3'd3, 2'd2, 2'd0, 2'd1), 4'd1, 0);
    run(op_i(3'd6, 2'd2, 2'd0, 2'd1), 4'd0, 0);
    run(op_i(3'd6, 2'd2, 2'd1, 2'd0), 4'd1, 0);
    run(op_i(3'd7, 2'd2, 2'd0, 2'd0), 4'd1, 0);
    run(ld_i(2'd2, 4'b1000), 4'b1000, 0);
    run(op_i(3'd4, 2'd3, 2'd0, 2'd2), 4'b1100, 0);
    run(ld_i(2'd3, 4'b1001), 4'b1001, 0);
    run(op_i(3'd5, 2'd2, 2'd3, 2'd0), 4'b0011, 0);
    run(op_i(3'd1, 2'd0, 2'd0, 2'd0), 4'hA, 0);
    run(op_i(3'd1, 2'd1, 2'd0, 2'd0), 4'h4, 0);
    run(op_i(3'd1, 2'd1, 2'd1, 2'd1), 4'h8, 3);
    @(posedge clk); #1;
    check("no_queued_instr", out_valid, 0);
    check("no_queued_busy", busy, 0);
    run(op_i(3'd1, 2'd2, 2'd0, 2'd0), 4'h4, 0);
    in_valid = 1'b1;
    instr = ld_i(2'd1, 4'd7);
    @(posedge clk); #3;
    in_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_retired", retired, 0);
    #2;
    rst = 1'b0;
    sb.delete();
    ret_m = '0;
    @(posedge clk); #1;
    run(op_i(3'd1, 2'd0, 2'd0, 2'd0), 4'd0, 0);
    run(op_i(3'd2, 2'd1, 2'd1, 2'd2), 4'd0, 0);
    run(op_i(3'd2, 2'd2, 2'd3, 2'd3), 4'd0, 0);
    for (int i = 3; i < 256; i++) run(ld_i(i[1:0], i[5:2]), i[5:2], 0);
    check("retired_wrap", retired, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
